// File: rtl/roll_scheduler.sv
// rtl/roll_scheduler.sv - two-player start arbitration onto one shared roll generator
// Optional generator timeout is enabled by defining ROLL_SCHED_TIMEOUT_EN.
module roll_scheduler #(
  parameter int W           = 4,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [1:0]   i_start,
  output logic         o_gen_start,
  output logic         o_gen_sel,
  input  logic         i_gen_done,
  input  logic [W-1:0] i_gen_value,
  output logic [W-1:0] o_value0,
  output logic [W-1:0] o_value1,
  output logic [1:0]   o_dark,
  output logic [1:0]   o_winner,
  output logic         o_err
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [1:0]     r_prev;
  logic [1:0]     r_pending;
  logic [1:0]     r_have;
  logic           r_sel;
  logic           r_last;
  logic [W-1:0]   r_value0;
  logic [W-1:0]   r_value1;
  logic [1:0]     r_winner;
  logic           r_err;

  logic [1:0]     w_rise;
  logic [1:0]     w_serving;
  logic [1:0]     w_grant_mask;
  logic [1:0]     w_latch_mask;
  logic           w_grant;
  logic           w_grant_sel;
  logic           w_latch;
  logic           w_timeout;
  logic           w_gen_start;
  logic           w_to_hit;

  assign w_rise    = i_start & ~r_prev;
  assign w_serving = (r_state != S_IDLE) ? (2'b01 << r_sel) : 2'b00;

`ifdef ROLL_SCHED_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CW-1:0] r_cnt;

  assign w_to_hit = (r_cnt == CW'(TIMEOUT_CYC - 1));

  // Counter is held at zero outside WAIT, so it restarts on every entry.
  always_ff @(posedge i_clk) begin
    if (i_rst || r_state != S_WAIT) begin
      r_cnt <= '0;
    end else if (!w_to_hit) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_to_hit = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_grant_sel = r_sel;
    w_latch     = 1'b0;
    w_timeout   = 1'b0;
    w_gen_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pending != 2'b00) begin
          w_grant     = 1'b1;
          w_grant_sel = (r_pending == 2'b11) ? ~r_last : r_pending[1];
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        w_gen_start = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (i_gen_done) begin
          w_latch     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_to_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_grant_mask = w_grant ? (2'b01 << w_grant_sel) : 2'b00;
  assign w_latch_mask = w_latch ? (2'b01 << r_sel) : 2'b00;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_prev    <= 2'b11;
      r_pending <= 2'b00;
      r_have    <= 2'b00;
      r_sel     <= 1'b0;
      r_last    <= 1'b1;
      r_value0  <= '0;
      r_value1  <= '0;
      r_winner  <= 2'b00;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_prev    <= i_start;
      // A rise for an already pending or in-service player is dropped.
      r_pending <= (r_pending | (w_rise & ~w_serving)) & ~w_grant_mask;
      r_have    <= (r_have & ~w_grant_mask) | w_latch_mask;
      if (w_grant) begin
        r_sel  <= w_grant_sel;
        r_last <= w_grant_sel;
      end
      if (w_latch && !r_sel) r_value0 <= i_gen_value;
      if (w_latch && r_sel)  r_value1 <= i_gen_value;
      if (r_have != 2'b11)            r_winner <= 2'b00;
      else if (r_value0 > r_value1)   r_winner <= 2'b01;
      else if (r_value1 > r_value0)   r_winner <= 2'b10;
      else                            r_winner <= 2'b11;
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign o_gen_start = w_gen_start;
  assign o_gen_sel   = r_sel;
  assign o_value0    = r_value0;
  assign o_value1    = r_value1;
  assign o_dark      = ~r_have;
  assign o_winner    = r_winner;
  assign o_err       = r_err;

endmodule

// File: tb/tb_roll_scheduler.sv
// tb/tb_roll_scheduler.sv - self-checking bench for roll_scheduler
module tb_roll_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] start;
  logic       gen_start;
  logic       gen_sel;
  logic       gen_done;
  logic [3:0] gen_value;
  logic [3:0] value0;
  logic [3:0] value1;
  logic [1:0] dark;
  logic [1:0] winner;
  logic       err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       pl;
    logic [3:0] val;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  roll_scheduler #(.W(4), .TIMEOUT_CYC(16)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .o_gen_start(gen_start),
    .o_gen_sel  (gen_sel),
    .i_gen_done (gen_done),
    .i_gen_value(gen_value),
    .o_value0   (value0),
    .o_value1   (value1),
    .o_dark     (dark),
    .o_winner   (winner),
    .o_err      (err)
  );

  task automatic do_reset(input logic [1:0] hold);
    start    = hold;
    gen_done = 1'b0;
    gen_value = 4'h0;
    rst      = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_start(output bit found);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (gen_start === 1'b1) found = 1'b1;
    end
  endtask

  task automatic pulse_done(input logic [3:0] v);
    gen_done  = 1'b1;
    gen_value = v;
    @(negedge clk);
    gen_done  = 1'b0;
    gen_value = 4'hF;
  endtask

  task automatic test_reset;
    int starts;
    do_reset(2'b11);
    starts = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (gen_start) starts++;
    end
    start = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (gen_start) starts++;
    end
    checks++;
    if (starts !== 0) begin errors++; $display("FAIL reset_nostart: starts=%0d required 0", starts); end
    checks++;
    if (dark !== 2'b11) begin errors++; $display("FAIL reset_dark: got %b required 11", dark); end
    checks++;
    if (winner !== 2'b00) begin errors++; $display("FAIL reset_winner: got %b required 00", winner); end
    checks++;
    if (value0 !== 4'd0 || value1 !== 4'd0) begin
      errors++; $display("FAIL reset_values: got %0d/%0d required 0/0", value0, value1);
    end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", err); end
  endtask

  task automatic test_single;
    exp_t e;
    exp_q.push_back('{pl: 1'b0, val: 4'd7});
    start = 2'b01;
    @(negedge clk);
    checks++;
    if (gen_start !== 1'b0) begin errors++; $display("FAIL single_early: gen_start=%b required 0", gen_start); end
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (gen_start !== 1'b1 || gen_sel !== e.pl) begin
      errors++; $display("FAIL single_grant: start=%b sel=%b required 1/%b", gen_start, gen_sel, e.pl);
    end
    @(negedge clk);
    checks++;
    if (gen_start !== 1'b0) begin errors++; $display("FAIL single_pulse: gen_start=%b required 0", gen_start); end
    @(negedge clk);
    pulse_done(e.val);
    checks++;
    if (value0 !== e.val) begin errors++; $display("FAIL single_value0: got %0d required %0d", value0, e.val); end
    checks++;
    if (dark !== 2'b10) begin errors++; $display("FAIL single_dark: got %b required 10", dark); end
    @(negedge clk);
    checks++;
    if (winner !== 2'b00) begin errors++; $display("FAIL single_winner: got %b required 00", winner); end
    start = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_both;
    bit   found;
    exp_t e;
    do_reset(2'b00);
    @(negedge clk);
    exp_q.push_back('{pl: 1'b0, val: 4'd3});
    exp_q.push_back('{pl: 1'b1, val: 4'd9});
    start = 2'b11;
    for (int k = 0; k < 2; k++) begin
      wait_start(found);
      checks++;
      if (!found) begin
        errors++; $display("FAIL both_start%0d: gen_start never seen required 1", k);
        exp_q.delete();
        return;
      end
      e = exp_q.pop_front();
      checks++;
      if (gen_sel !== e.pl) begin errors++; $display("FAIL both_sel%0d: got %b required %b", k, gen_sel, e.pl); end
      repeat (2) @(negedge clk);
      pulse_done(e.val);
      checks++;
      if ((e.pl ? value1 : value0) !== e.val) begin
        errors++; $display("FAIL both_value%0d: got %0d required %0d", k, e.pl ? value1 : value0, e.val);
      end
    end
    checks++;
    if (winner !== 2'b00) begin errors++; $display("FAIL both_winner_early: got %b required 00", winner); end
    @(negedge clk);
    checks++;
    if (winner !== 2'b10) begin errors++; $display("FAIL both_winner: got %b required 10", winner); end
    start = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_reroll;
    bit   found;
    exp_t e;
    exp_q.push_back('{pl: 1'b0, val: 4'd9});
    start = 2'b01;
    wait_start(found);
    checks++;
    if (!found) begin
      errors++; $display("FAIL reroll_start: gen_start never seen required 1");
      exp_q.delete();
      return;
    end
    e = exp_q.pop_front();
    @(negedge clk);
    checks++;
    if (winner !== 2'b00) begin errors++; $display("FAIL reroll_winner_clear: got %b required 00", winner); end
    checks++;
    if (dark !== 2'b01) begin errors++; $display("FAIL reroll_dark_wait: got %b required 01", dark); end
    @(negedge clk);
    pulse_done(e.val);
    checks++;
    if (dark !== 2'b00 || value0 !== e.val) begin
      errors++; $display("FAIL reroll_latch: dark=%b value0=%0d required 00/%0d", dark, value0, e.val);
    end
    @(negedge clk);
    checks++;
    if (winner !== 2'b11) begin errors++; $display("FAIL reroll_tie: got %b required 11", winner); end
    start = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_drop;
    bit   found;
    int   starts;
    exp_t e;
    exp_q.push_back('{pl: 1'b1, val: 4'd5});
    start = 2'b10;
    wait_start(found);
    checks++;
    if (!found) begin
      errors++; $display("FAIL drop_start: gen_start never seen required 1");
      exp_q.delete();
      return;
    end
    e = exp_q.pop_front();
    checks++;
    if (gen_sel !== e.pl) begin errors++; $display("FAIL drop_sel: got %b required %b", gen_sel, e.pl); end
    starts = 0;
    for (int i = 0; i < 6; i++) begin
      start[1] = ~start[1];
      @(negedge clk);
      if (gen_start) starts++;
    end
    start[1] = 1'b1;
    pulse_done(e.val);
    checks++;
    if (value1 !== e.val) begin errors++; $display("FAIL drop_value1: got %0d required %0d", value1, e.val); end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (gen_start) starts++;
    end
    checks++;
    if (starts !== 0) begin errors++; $display("FAIL drop_extra_starts: got %0d required 0", starts); end
    start = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_timeout;
    bit found;
    do_reset(2'b00);
    @(negedge clk);
    start = 2'b01;
    wait_start(found);
    checks++;
    if (!found) begin errors++; $display("FAIL to_start: gen_start never seen required 1"); return; end
    repeat (16) @(negedge clk);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL to_err_early: got %b required 0", err); end
    @(negedge clk);
`ifdef ROLL_SCHED_TIMEOUT_EN
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL to_err: got %b required 1", err); end
    checks++;
    if (dark !== 2'b11) begin errors++; $display("FAIL to_dark: got %b required 11", dark); end
    start = 2'b11;
    wait_start(found);
    checks++;
    if (!found || gen_sel !== 1'b1) begin
      errors++; $display("FAIL to_idle_regrant: found=%b sel=%b required 1/1", found, gen_sel);
    end
`else
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL to_err_off: got %b required 0", err); end
    start = 2'b11;
    wait_start(found);
    checks++;
    if (found) begin errors++; $display("FAIL to_stuck_wait: gen_start=1 required no new grant"); end
`endif
    do_reset(2'b00);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 2'b11;
    gen_done  = 1'b0;
    gen_value = 4'h0;
    test_reset();
    test_single();
    test_both();
    test_reroll();
    test_drop();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/roll_scheduler.md
Name: roll_scheduler

Overview:
- Arbitrates two players' debounced start buttons onto one shared random-value generator.
- Sequences each roll with a start/done handshake to the generator.
- Latches one 4-bit result per player and drives per-player blanking for the 7-segment decoders.
- Compares the two latched results and reports a winner; sits between the Debounce instances and a single shared generator.

Parameters:
W, 4, result width in bits (matches the hex decoder input)
TIMEOUT_CYC, 1048576, cycles to wait for i_gen_done before aborting (used only with the optional feature)

Ports:
i_clk  in  1  system clock (CLOCK_50 domain)
i_rst  in  1  synchronous, active-high reset
i_start  in  2  debounced start levels, bit p = player p, active-high; block edge-detects
o_gen_start  out  1  one-cycle pulse: begin a roll on the shared generator
o_gen_sel  out  1  player currently being served; held stable from grant through done
i_gen_done  in  1  one-cycle pulse from generator: roll finished, i_gen_value valid
i_gen_value  in  W  final rolled value, sampled only when i_gen_done=1 in WAIT
o_value0  out  W  latched result, player 0
o_value1  out  W  latched result, player 1
o_dark  out  2  bit p=1 blanks player p's display
o_winner  out  2  00 no verdict, 01 player0, 10 player1, 11 tie
o_err  out  1  sticky generator-timeout flag

Behaviour:
- Reset (i_rst=1 at a clock edge), effective that edge regardless of state:
  - state=IDLE, pending=00, have=00, values=0, o_dark=11, o_winner=00, o_gen_start=0, o_gen_sel=0, o_err=0.
  - last-served pointer=1, so player 0 wins the first tie in arbitration.
  - Edge-detect history=11, so a button held through reset does not trigger.
- Edge detect: rise[p] = i_start[p] & ~prev[p]; prev updates every cycle.
- Pending: rise[p] sets pending[p], except when p already pending or p being served (state GRANT/WAIT with o_gen_sel=p); such rises are dropped.
- FSM (IDLE, GRANT, WAIT):
  - IDLE: if pending != 00, pick requester (round-robin, see below), set o_gen_sel, clear pending[sel] and have[sel], go to GRANT. Otherwise stay.
  - GRANT: o_gen_start=1 for exactly this one cycle; go to WAIT.
  - WAIT: on i_gen_done, latch i_gen_value into o_value[sel], set have[sel], go to IDLE.
- Round-robin:
  - If both pending, grant the player not equal to the last-served pointer.
  - If one pending, grant it.
  - Pointer updates at grant.
- Latency, idle block: rise sampled at edge N -> pending after N -> grant decision at N+1 -> o_gen_start high during cycle N+1..N+2. Value and have update at the edge sampling i_gen_done. Next grant is possible no earlier than one cycle after return to IDLE.
- i_gen_done outside WAIT is ignored; i_gen_value is ignored unless done is high.
- o_dark[p] = ~have[p], registered: dark from grant until that player's result lands, and before the first result.
- o_winner: registered one cycle after have and values settle.
  - If have=11, compare unsigned: larger value wins; equal gives 11.
  - Otherwise 00.
  - A new grant to either player forces 00 on the following cycle.
- Simultaneous rises on both bits: both pending; served back-to-back in round-robin order.
- o_err is cleared only by reset.

Optional Feature:
- Macro ROLL_SCHED_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT (cleared on entry).
  - If it reaches TIMEOUT_CYC-1 without i_gen_done: set o_err=1, leave have[sel]=0 (display stays dark), return to IDLE.
  - A done pulse arriving on that same cycle takes priority and the roll completes normally.
- Undefined: no counter; WAIT holds indefinitely; o_err tied 0.

Test Plan:
- Reset with i_start=11 held, then release/hold -> no o_gen_start; o_dark=11, o_winner=00, values=0.
- i_start[0] rises at edge N; generator replies done with value 7 three cycles after start pulse -> o_gen_start pulses in cycle N+1..N+2 with o_gen_sel=0; o_value0=7; o_dark=10.
- Both bits rise same cycle, first done value 3, second 9 -> player 0 served first (value0=3), then player 1 (value1=9); o_winner=10 one cycle after second latch.
- Player 0 re-rolls to 9 -> o_winner goes 00 the cycle after grant, o_dark[0]=1 until done, then o_winner=11 (tie).
- i_start[1] toggles repeatedly while player 1 is in WAIT -> rises dropped; exactly one o_gen_start for player 1.
- With ROLL_SCHED_TIMEOUT_EN, TIMEOUT_CYC=16, no done -> o_err=1 after 16 WAIT cycles, FSM IDLE, o_dark[sel]=1. Without the macro -> stays in WAIT, o_err=0.
